// File: rtl/tt_test_pkg.sv
// -----------------------------------------------------------------------------
// tt_test_pkg
// Shared definitions for the SPI test-target slice: frame geometry, the
// bit-counter width and the frame FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package tt_test_pkg;

  // Frame geometry: 8 command bits (W + address field) then 8 data bits
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int W_BIT      = 15;

  // Bit counter must be able to hold the value FRAME_BITS
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

  // Defaults for the top-level parameters
  localparam int         DEF_NREG    = 8;
  localparam logic [7:0] DEF_RST_VAL = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/tt_sync_edge.sv
// -----------------------------------------------------------------------------
// tt_sync_edge
// N-stage synchroniser for an asynchronous input followed by rising/falling
// edge detection in the clk domain.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input
//   q     out synchronised level
//   rise  out one-clk pulse on a synchronised 0->1 transition
//   fall  out one-clk pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module tt_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RST_LVL}};
      prev_r <= RST_LVL;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/tt_spi_test_target.sv
// -----------------------------------------------------------------------------
// tt_spi_test_target
// SPI mode-0 target giving an off-chip host write/read access to an
// NREG x 8-bit control register file. All SPI pins are oversampled in the clk
// domain. Frame: {W, addr[6:0], data[7:0]}, MSB first. The top address reads
// live status_in and ignores writes.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   sclk, cs_n    SPI clock (idle low) and chip select (active low)
//   mosi, miso    serial data in / out, MSB first
//   miso_oe       output enable for the miso pin while selected
//   regs          flattened registers, reg k at [8k+7:8k], top slot = 0
//   status_in     live status readable at address NREG-1
//   wr_strobe     one-clk pulse when a register write commits
//   wr_addr       address of the committed write
// -----------------------------------------------------------------------------
module tt_spi_test_target
  import tt_test_pkg::*;
#(
  parameter int         NREG        = DEF_NREG,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RST_VAL     = DEF_RST_VAL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    miso_oe,
  output logic [NREG*8-1:0]       regs,
  input  logic [7:0]              status_in,
  output logic                    wr_strobe,
  output logic [$clog2(NREG)-1:0] wr_addr
);

  localparam int            AW       = $clog2(NREG);
  localparam logic [AW-1:0] TOP_ADDR = AW'(NREG - 1);

  // Internal reset: asserts asynchronously, releases on a clk edge
  logic [1:0] rst_sync_r;
  logic       rst_int_n_s;

  // Reset release synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic                   sclk_q_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   cs_q_s;
  logic                   mosi_q_s;

  tt_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_LVL (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_int_n_s),
    .d     (sclk),
    .q     (sclk_q_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  // cs_n and mosi use the same depth as sclk so mosi lines up with the rise
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
    end
  end

  assign cs_q_s   = cs_sync_r[SYNC_STAGES-1];
  assign mosi_q_s = mosi_sync_r[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e           state_r;
  state_e           state_s;
  logic             shift_en_s;
  logic             cmd_end_s;
  logic             frame_end_s;
  logic             miso_step_s;
  logic             abort_s;
  logic [CNT_W-1:0] bit_cnt_r;

  // Frame state register
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle datapath controls; deselect always wins
  always_comb begin
    state_s     = state_r;
    shift_en_s  = 1'b0;
    cmd_end_s   = 1'b0;
    frame_end_s = 1'b0;
    miso_step_s = 1'b0;
    abort_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!cs_q_s) begin
          state_s = CMD;
        end else begin
          state_s = IDLE;
        end
      end
      CMD: begin
        if (cs_q_s) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (sclk_rise_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == CMD_LAST) begin
            cmd_end_s = 1'b1;
            state_s   = DATA;
          end else begin
            state_s = CMD;
          end
        end else begin
          state_s = CMD;
        end
      end
      DATA: begin
        if (cs_q_s) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else if (sclk_rise_s) begin
          shift_en_s = 1'b1;
          if (bit_cnt_r == FRAME_LAST) begin
            frame_end_s = 1'b1;
            state_s     = DONE;
          end else begin
            state_s = DATA;
          end
        end else if (sclk_fall_s) begin
          miso_step_s = 1'b1;
          state_s     = DATA;
        end else begin
          state_s = DATA;
        end
      end
      DONE: begin
        // Extra sclk edges are ignored until deselect
        if (cs_q_s) begin
          abort_s = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        abort_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift path, command latch and read shadow
  // ---------------------------------------------------------------------------
  logic [NREG-1:0][7:0] reg_file_r;
  logic [6:0]           shift_r;
  logic                 w_r;
  logic [AW-1:0]        addr_r;
  logic [7:0]           shadow_r;
  logic [7:0]           data_r;
  logic                 commit_r;
  logic                 miso_r;
  logic [AW-1:0]        addr_s;
  logic [7:0]           data_s;

  // The 8th/16th bit is still on mosi_q_s when the byte completes
  assign addr_s = {shift_r[AW-2:0], mosi_q_s};
  assign data_s = {shift_r, mosi_q_s};

  // Serial datapath: sampling on rise, miso update on fall
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      bit_cnt_r <= '0;
      shift_r   <= 7'd0;
      w_r       <= 1'b0;
      addr_r    <= '0;
      shadow_r  <= 8'h00;
      data_r    <= 8'h00;
      commit_r  <= 1'b0;
      miso_r    <= 1'b0;
    end else begin
      commit_r <= 1'b0;
      if (abort_s) begin
        bit_cnt_r <= '0;
        miso_r    <= 1'b0;
      end else begin
        if (shift_en_s) begin
          bit_cnt_r <= bit_cnt_r + 5'd1;
          shift_r   <= {shift_r[5:0], mosi_q_s};
        end
        if (cmd_end_s) begin
          // shift_r[6] holds frame bit 15 (W) at this point
          w_r      <= shift_r[6];
          addr_r   <= addr_s;
          shadow_r <= (addr_s == TOP_ADDR) ? status_in : reg_file_r[addr_s];
        end
        if (frame_end_s) begin
          data_r   <= data_s;
          commit_r <= w_r & (addr_r != TOP_ADDR);
          miso_r   <= 1'b0;
        end
        if (miso_step_s && !w_r) begin
          miso_r   <= shadow_r[7];
          shadow_r <= {shadow_r[6:0], 1'b0};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file and write strobe
  // ---------------------------------------------------------------------------
  logic             wr_strobe_r;
  logic [AW-1:0]    wr_addr_r;

  // Write commit one clk after the last data bit; top slot stays 0
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      for (int k = 0; k < NREG; k++) begin
        reg_file_r[k] <= (k == NREG - 1) ? 8'h00 : RST_VAL;
      end
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
    end else begin
      wr_strobe_r <= 1'b0;
      if (commit_r) begin
        reg_file_r[addr_r] <= data_r;
        wr_strobe_r        <= 1'b1;
        wr_addr_r          <= addr_r;
      end
    end
  end

  logic miso_oe_r;

  // Output enable follows the synchronised chip select
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      miso_oe_r <= 1'b0;
    end else begin
      miso_oe_r <= ~cs_q_s;
    end
  end

  assign miso      = miso_r;
  assign miso_oe   = miso_oe_r;
  assign regs      = reg_file_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;

endmodule

// File: tb/tb_tt_spi_test_target.sv
// -----------------------------------------------------------------------------
// tb_tt_spi_test_target
// Directed SPI host driving tt_spi_test_target. Expected writes and expected
// miso frames are queued when each frame is issued; independent monitors pop
// and compare when the DUT strobes a write or the host deselects.
// -----------------------------------------------------------------------------
module tb_tt_spi_test_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [63:0] regs;
  logic [7:0]  status_in = 8'h00;
  logic        wr_strobe;
  logic [2:0]  wr_addr;

  tt_spi_test_target dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .regs      (regs),
    .status_in (status_in),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  model [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_reg%0d", name, k), {24'h0, regs[8*k +: 8]}, {24'h0, model[k]});
    end
  endtask

  task automatic spi_frame(input logic [15:0] frame, input int nbits, input int half, input int gap);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("miso_oe_active", {31'h0, miso_oe}, 32'h1);
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) begin
        mosi = frame[15-i];
      end else begin
        mosi = 1'b1;
      end
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (gap) @(negedge clk);
    chk("miso_oe_idle", {31'h0, miso_oe}, 32'h0);
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && wr_strobe === 1'b1) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_strobe_unexpected actual addr=%0d required=no strobe", wr_addr);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        chk("wr_addr", {29'h0, wr_addr}, {29'h0, e.addr});
        chk("wr_data", {24'h0, regs[8*e.addr +: 8]}, {24'h0, e.data});
      end
    end
  end

  // miso monitor: host-side deserialiser, compares each complete frame
  logic [15:0] rx_sh = 16'h0;
  int          rx_cnt = 0;

  always @(negedge cs_n) begin
    rx_sh  = 16'h0;
    rx_cnt = 0;
  end

  always @(posedge sclk) begin
    if (!cs_n && rx_cnt < 16) begin
      rx_sh  = {rx_sh[14:0], miso};
      rx_cnt = rx_cnt + 1;
    end
  end

  always @(posedge cs_n) begin
    if (rx_cnt == 16) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL miso_frame_unexpected actual=%0h required=none", rx_sh);
      end else begin
        chk("miso_frame", {16'h0, rx_sh}, {16'h0, rd_q.pop_front()});
      end
    end
    rx_cnt = 0;
  end

  logic [7:0]  fast_data [0:6];
  logic [15:0] fr;

  initial begin
    fast_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h7E};
    for (int k = 0; k < 8; k++) model[k] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check_regs("reset");
    chk("reset_miso", {31'h0, miso}, 32'h0);
    chk("reset_miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("reset_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    chk("reset_wr_addr", {29'h0, wr_addr}, 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0xA5 to addr 3, then read it back
    wr_q.push_back('{addr: 3'd3, data: 8'hA5}); model[3] = 8'hA5; rd_q.push_back(16'h0000);
    spi_frame(16'h83A5, 16, 4, 6);
    rd_q.push_back(16'h00A5);
    spi_frame(16'h0300, 16, 4, 6);
    check_regs("write_a5");

    // Status read and dropped status write
    status_in = 8'h3C;
    rd_q.push_back(16'h003C);
    spi_frame(16'h0700, 16, 4, 6);
    rd_q.push_back(16'h0000);
    spi_frame(16'h87FF, 16, 4, 6);
    check_regs("status_write");

    // Abort after 12 bits, then the full frame
    spi_frame(16'h8155, 12, 4, 6);
    check_regs("abort");
    wr_q.push_back('{addr: 3'd1, data: 8'h55}); model[1] = 8'h55; rd_q.push_back(16'h0000);
    spi_frame(16'h8155, 16, 4, 6);

    // Overrun: 20 pulses, only one commit
    wr_q.push_back('{addr: 3'd2, data: 8'hC3}); model[2] = 8'hC3; rd_q.push_back(16'h0000);
    spi_frame(16'h82C3, 20, 4, 6);
    check_regs("overrun");

    // Upper address-field bits are ignored (field 0x70 -> addr 0)
    wr_q.push_back('{addr: 3'd0, data: 8'h12}); model[0] = 8'h12; rd_q.push_back(16'h0000);
    spi_frame(16'hF012, 16, 4, 6);
    rd_q.push_back(16'h0012);
    spi_frame(16'h7800, 16, 4, 6);

    // Speed corner: sclk = clk/4, minimum cs_n gap
    for (int k = 0; k < 7; k++) begin
      wr_q.push_back('{addr: 3'(k), data: fast_data[k]});
      model[k] = fast_data[k];
      rd_q.push_back(16'h0000);
      spi_frame({1'b1, 4'b0000, 3'(k), fast_data[k]}, 16, 2, 4);
    end
    check_regs("fast");

    // Reset in the middle of a read frame
    fr = 16'h0300;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mosi = fr[15-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) model[k] = 8'h00;
    check_regs("midreset");
    chk("midreset_miso", {31'h0, miso}, 32'h0);
    chk("midreset_miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("midreset_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    chk("midreset_wr_addr", {29'h0, wr_addr}, 32'h0);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Fresh traffic after reset
    wr_q.push_back('{addr: 3'd5, data: 8'h99}); model[5] = 8'h99; rd_q.push_back(16'h0000);
    spi_frame(16'h8599, 16, 4, 6);
    rd_q.push_back(16'h0099);
    spi_frame(16'h0500, 16, 4, 6);
    check_regs("post_reset");

    repeat (10) @(negedge clk);
    chk("wr_queue_drained", wr_q.size(), 32'h0);
    chk("rd_queue_drained", rd_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_spi_test_target.md
Name: tt_spi_test_target

Overview:
SPI mode-0 target (responder) that lets an off-chip host configure and read back the test-chip's control registers via the dedicated/bidir pins of the tt_um wrapper. It receives 16-bit frames, writes or reads an internal 8x8-bit register file, and exposes the register contents as static control outputs for the analog/test logic. All SPI inputs are oversampled in the system clock domain. No SPI-clock-domain logic.

Parameters:
NREG, 8, number of 8-bit registers (address width = clog2(NREG)); the top address is read-only status
SYNC_STAGES, 2, synchroniser depth on sclk, cs_n and mosi (min 2)
RST_VAL, 8'h00, reset value of every writable register

Ports:
clk  in  1  system clock; fclk must be >= 4x sclk frequency
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, idle low (mode 0)
cs_n  in  1  SPI chip select, active low
mosi  in  1  host-to-target serial data, MSB first
miso  out  1  target-to-host serial data, MSB first
miso_oe  out  1  output enable for the miso uio pin; 1 while cs_n (synced) low
regs  out  NREG*8  flattened writable registers; reg k at [8k+7:8k]; top slot reads as 0
status_in  in  8  live status, readable at address NREG-1
wr_strobe  out  1  one-clk pulse when a register write commits
wr_addr  out  clog2(NREG)  address of the committed write, valid with wr_strobe

Behaviour:
- Reset (async assert, sync deassert internally): state IDLE, all writable regs = RST_VAL, miso=0, miso_oe=0, wr_strobe=0, wr_addr=0, bit counter=0, shift regs=0; synchroniser flops reset to idle values (sclk=0, cs_n=1, mosi=0).
- Frame: 16 bits, MSB first. bit15 = W (1 write, 0 read); bits14:8 = address field, only the low clog2(NREG) bits used, rest ignored; bits7:0 = write data (ignored on read).
- Edge detect on synced sclk: rise = sample mosi into shift reg, increment bit count; fall = update miso.
- FSM: IDLE -> CMD on synced cs_n falling. CMD: collect 8 bits; on 8th rise latch W/addr, load read shadow = register (or status_in if addr = NREG-1, sampled at that clk) -> DATA. DATA: on each fall drive shadow MSB then shift; collect 8 bits; on 16th rise -> DONE. DONE: ignore further sclk edges; -> IDLE on cs_n high.
- miso = 0 during CMD and after DONE; first data bit (bit7) driven on the fall following the 8th rise, so it is valid before the 9th rise. On a write frame miso stays 0.
- Write commit: in the clk after the 16th rise, if W=1 and addr != NREG-1: regs[addr] <= data, wr_strobe=1 for exactly 1 clk, wr_addr=addr. Writes to the status address are dropped, no strobe.
- Latency: regs update and wr_strobe appear SYNC_STAGES+2 clk after the 16th sclk rising edge at the pin.
- cs_n high mid-frame (any state): abort, no write, no strobe, counter cleared, miso=0, -> IDLE. cs_n low again starts a fresh frame.
- Extra sclk pulses beyond 16 in one cs_n window: ignored. Fewer than 16: aborted as above.
- Back-to-back frames: cs_n must be high >= SYNC_STAGES+2 clk; shorter gaps are not required to be detected.
- Reset mid-frame: everything returns to reset values immediately; partial frame discarded.

Decomposition:
- Shared package tt_test_pkg: FRAME_BITS=16, CMD_BITS=8, W bit position, state enum (IDLE, CMD, DATA, DONE), default NREG/RST_VAL.
- One sub-module: tt_sync_edge (N-stage synchroniser + rise/fall detect), instantiated for sclk; plain synchronisers for cs_n and mosi. Register file stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-run -> regs all 8'h00, miso=0, miso_oe=0, wr_strobe=0 without a clk edge.
- Write then read: write 0xA5 to addr 3 (frame 0x83A5) -> regs[31:24]=0xA5, one wr_strobe with wr_addr=3; read frame 0x0300 -> miso returns 0xA5 on bits 7:0.
- Status read: status_in=0x3C, read addr 7 (0x0700) -> miso 0x3C; write 0x87FF -> no strobe, regs unchanged.
- Abort: raise cs_n after 12 bits of 0x8155 -> regs[15:8] unchanged, no wr_strobe; next full frame 0x8155 -> regs[15:8]=0x55.
- Overrun: 20 sclk pulses of 0x82C3 then 4 extra bits -> regs[23:16]=0xC3, exactly one wr_strobe.
- Speed corner: sclk = clk/4, back-to-back frames with minimum cs_n gap -> all writes committed correctly, miso_oe tracks cs_n.
